// File: rtl/my_iterative_rightshifter_pkg.sv
// Shared widths, FSM encoding and stage-counter constants for the iterative right shifter.
package my_iterative_rightshifter_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_SHAMT_WIDTH = 5;

  localparam int STAGE_WIDTH = 3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_LAST = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/my_iterative_rightshifter_stage.sv
// One binary right-shift stage: shifts by 2^stage_sel with a caller-chosen fill bit.
module my_rightshift_stage
  import my_iterative_rightshifter_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SHAMT_WIDTH = DEF_SHAMT_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic [STAGE_WIDTH-1:0] stage_sel,
  input  logic                   enable,
  input  logic                   fill_bit,
  output logic [DATA_WIDTH-1:0]  data_out
);

  logic [DATA_WIDTH-1:0] shifted [SHAMT_WIDTH];

  genvar gi;
  generate
    for (gi = 0; gi < SHAMT_WIDTH; gi++) begin : g_dist
      localparam int DIST = 1 << gi;
      assign shifted[gi] = {{DIST{fill_bit}}, data_in[DATA_WIDTH-1:DIST]};
    end
  endgenerate

  // Unmatched selects fall through to pass-through, so no X can leak out.
  always_comb begin
    data_out = data_in;
    for (int i = 0; i < SHAMT_WIDTH; i++) begin
      if (enable && (stage_sel == STAGE_WIDTH'(i))) begin
        data_out = shifted[i];
      end
    end
  end

endmodule

// File: rtl/my_iterative_rightshifter.sv
// Multicycle right shifter: one binary stage per cycle, fixed latency, start/ready handshake.
module my_iterative_rightshifter
  import my_iterative_rightshifter_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SHAMT_WIDTH = DEF_SHAMT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   ctrl_start,
  input  logic [DATA_WIDTH-1:0]  data_operandA,
  input  logic [SHAMT_WIDTH-1:0] ctrl_shiftamt,
  input  logic                   ctrl_arith,
  output logic [DATA_WIDTH-1:0]  data_result,
  output logic                   data_resultRDY,
  output logic                   busy
);

  state_t                 state_reg, state_next;
  logic [DATA_WIDTH-1:0]  acc_reg, acc_next;
  logic [SHAMT_WIDTH-1:0] amt_reg, amt_next;
  logic                   arith_reg, arith_next;
  logic [STAGE_WIDTH-1:0] stage_reg, stage_next;
  logic                   rdy_reg, rdy_next;

  logic [DATA_WIDTH-1:0]  stage_out;
  logic                   fill_bit;

  // The sign bit never changes under arithmetic fill, so the live MSB is a safe fill source.
  assign fill_bit = arith_reg & acc_reg[DATA_WIDTH-1];

  my_rightshift_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_WIDTH(SHAMT_WIDTH)
  ) u_stage (
    .data_in  (acc_reg),
    .stage_sel(stage_reg),
    .enable   (amt_reg[stage_reg]),
    .fill_bit (fill_bit),
    .data_out (stage_out)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      amt_reg   <= '0;
      arith_reg <= 1'b0;
      stage_reg <= '0;
      rdy_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      amt_reg   <= amt_next;
      arith_reg <= arith_next;
      stage_reg <= stage_next;
      rdy_reg   <= rdy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    amt_next   = amt_reg;
    arith_next = arith_reg;
    stage_next = stage_reg;
    rdy_next   = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (ctrl_start) begin
          acc_next   = data_operandA;
          amt_next   = ctrl_shiftamt;
          arith_next = ctrl_arith;
          stage_next = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // Starts arriving here are deliberately ignored.
        acc_next   = stage_out;
        stage_next = stage_reg + 1'b1;
        if (stage_reg == STAGE_LAST) begin
          stage_next = '0;
          state_next = DONE;
          rdy_next   = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign data_result    = acc_reg;
  assign data_resultRDY = rdy_reg;
  assign busy           = (state_reg == SHIFT);

endmodule

// File: tb/tb_my_iterative_rightshifter.sv
// Directed bench: table of shift vectors plus hand-written busy-start, reset and back-to-back sequences.
module tb_my_iterative_rightshifter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_start;
  logic [31:0] data_operandA;
  logic [4:0]  ctrl_shiftamt;
  logic        ctrl_arith;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs [9];

  my_iterative_rightshifter dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ctrl_start    (ctrl_start),
    .data_operandA (data_operandA),
    .ctrl_shiftamt (ctrl_shiftamt),
    .ctrl_arith    (ctrl_arith),
    .data_result   (data_result),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Edge E0: start sampled, operation captured.
  task automatic launch(input logic [31:0] a, input logic [4:0] s, input logic ar, input string name);
    data_operandA = a;
    ctrl_shiftamt = s;
    ctrl_arith    = ar;
    ctrl_start    = 1'b1;
    tick();
    ctrl_start = 1'b0;
    check({name, " busy@E0"}, 32'(busy), 32'd1);
    check({name, " rdy@E0"}, 32'(data_resultRDY), 32'd0);
  endtask

  // Edges E1..E5: busy throughout, RDY only after E5.
  task automatic finish_op(input logic [31:0] exp, input string name);
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("%s busy@E%0d", name, e), 32'(busy), 32'd1);
      check($sformatf("%s rdy@E%0d", name, e), 32'(data_resultRDY), 32'd0);
    end
    tick();
    check({name, " rdy@E5"}, 32'(data_resultRDY), 32'd1);
    check({name, " busy@E5"}, 32'(busy), 32'd0);
    check({name, " result"}, data_result, exp);
  endtask

  initial begin
    vecs[0] = '{32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000};
    vecs[1] = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF};
    vecs[2] = '{32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000};
    vecs[3] = '{32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF};
    vecs[4] = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001};
    vecs[5] = '{32'hF0F0_F0F0, 5'd5,  1'b1, 32'hFF87_8787};
    vecs[6] = '{32'h1234_5678, 5'd12, 1'b0, 32'h0001_2345};
    vecs[7] = '{32'h8000_0001, 5'd1,  1'b1, 32'hC000_0000};
    vecs[8] = '{32'hF0F0_F0F0, 5'd5,  1'b0, 32'h0787_8787};

    reset_n       = 1'b0;
    ctrl_start    = 1'b0;
    data_operandA = '0;
    ctrl_shiftamt = '0;
    ctrl_arith    = 1'b0;
    repeat (2) tick();
    check("reset result", data_result, 32'd0);
    check("reset rdy", 32'(data_resultRDY), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].a, vecs[i].shamt, vecs[i].arith, $sformatf("vec%0d", i));
      finish_op(vecs[i].expected, $sformatf("vec%0d", i));
      $display("vec%0d: A=0x%08h shamt=%0d arith=%0d result=0x%08h expected=0x%08h",
               i, vecs[i].a, vecs[i].shamt, vecs[i].arith, data_result, vecs[i].expected);
      tick();
      check($sformatf("vec%0d rdy@E6", i), 32'(data_resultRDY), 32'd0);
      check($sformatf("vec%0d busy@E6", i), 32'(busy), 32'd0);
    end

    // Start while busy: second start at E2 must be ignored.
    launch(32'h0000_F000, 5'd8, 1'b0, "busy_start");
    tick();
    data_operandA = 32'hFFFF_FFFF;
    ctrl_shiftamt = 5'd1;
    ctrl_start    = 1'b1;
    tick();
    ctrl_start = 1'b0;
    check("busy_start busy@E2", 32'(busy), 32'd1);
    repeat (2) tick();
    check("busy_start rdy@E4", 32'(data_resultRDY), 32'd0);
    tick();
    check("busy_start rdy@E5", 32'(data_resultRDY), 32'd1);
    check("busy_start result", data_result, 32'h0000_00F0);
    $display("busy_start: result=0x%08h expected=0x000000f0", data_result);
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("busy_start idle rdy+%0d", c), 32'(data_resultRDY), 32'd0);
      check($sformatf("busy_start idle busy+%0d", c), 32'(busy), 32'd0);
    end
    check("busy_start held result", data_result, 32'h0000_00F0);

    // Reset mid-operation between E2 and E3.
    launch(32'hFFFF_0000, 5'd3, 1'b1, "midreset");
    repeat (2) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset result", data_result, 32'd0);
    check("midreset rdy", 32'(data_resultRDY), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("midreset no rdy+%0d", c), 32'(data_resultRDY), 32'd0);
    end
    launch(32'h0000_0100, 5'd8, 1'b0, "postreset");
    finish_op(32'h0000_0001, "postreset");
    $display("midreset: post-reset result=0x%08h expected=0x00000001", data_result);
    tick();

    // Back-to-back: new start presented during the RDY cycle.
    launch(32'h8000_0000, 5'd4, 1'b0, "b2b_first");
    finish_op(32'h0800_0000, "b2b_first");
    data_operandA = 32'hF000_0000;
    ctrl_shiftamt = 5'd28;
    ctrl_arith    = 1'b1;
    ctrl_start    = 1'b1;
    tick();
    ctrl_start = 1'b0;
    check("b2b rdy@E6", 32'(data_resultRDY), 32'd0);
    check("b2b busy@E6", 32'(busy), 32'd1);
    finish_op(32'hFFFF_FFFF, "b2b_second");
    $display("b2b: second result=0x%08h expected=0xffffffff", data_result);
    tick();
    check("b2b rdy after", 32'(data_resultRDY), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/my_iterative_rightshifter.md
Name: my_iterative_rightshifter

Overview:
- Multicycle 32-bit right shifter that resolves a 5-bit shift amount one binary stage per cycle: 1, 2, 4, 8, then 16 bit positions.
- Supports logical shift (zero fill) and arithmetic shift (sign fill).
- Complements the combinational left-shift path. Sits beside the ALU as an execute-stage multicycle unit with a start/ready handshake, like the mult/div unit.
- Fixed latency, independent of shift amount.

Parameters:
- DATA_WIDTH, 32, operand/result width; must equal 2**SHAMT_WIDTH.
- SHAMT_WIDTH, 5, shift-amount width; also the number of shift stages.

Ports:
- clock  input  1  single clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- ctrl_start  input  1  pulse to launch an operation; sampled on the rising edge
- data_operandA  input  DATA_WIDTH  value to shift; captured at an accepted start
- ctrl_shiftamt  input  SHAMT_WIDTH  shift amount 0..31; captured at an accepted start
- ctrl_arith  input  1  1 = arithmetic (fill with operand[31]), 0 = logical (fill with 0); captured at an accepted start
- data_result  output  DATA_WIDTH  shifted value; valid while data_resultRDY=1, held until the next accepted start
- data_resultRDY  output  1  registered one-cycle pulse marking result valid
- busy  output  1  high while in SHIFT

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, accumulator=0, amt=0, arith=0, stage counter=0.
  - data_result=0, data_resultRDY=0, busy=0.
  - Applies immediately, including mid-operation; the in-flight operation is discarded with no RDY pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ctrl_start=1 at edge E0: capture operandA into the accumulator; capture shiftamt and arith; stage=0; go to SHIFT.
  - busy rises after E0.
- SHIFT, at edges E1..E5, for stage k = 0..4:
  - If amt[k]=1: accumulator <= accumulator >> 2^k, with vacated MSBs filled by (arith ? accumulator[31] : 0).
  - If amt[k]=0: accumulator unchanged.
  - stage increments each edge.
  - At E5 (stage 4 done): go to DONE, data_resultRDY<=1, busy<=0.
- Sign handling: under arithmetic fill the sign bit is invariant across stages, so using the current accumulator[31] is correct.
- DONE (the cycle between E5 and E6):
  - data_resultRDY=1 and data_result equals the final accumulator.
  - At E6: RDY<=0.
  - If ctrl_start=1 at E6: accept a new operation (capture, go to SHIFT); otherwise go to IDLE.
- Latency: start sampled at E0 -> RDY high in the cycle after E5. Throughput is one operation per 6 cycles.
- ctrl_start while in SHIFT is ignored. Captured operands and busy are unaffected, with no error flag.
- shiftamt=0 still takes the full latency; result equals the operand.
- data_result is a direct view of the accumulator. It changes only during SHIFT and holds after DONE until the next capture.
- No X propagation: all registers have reset values; the stage-select mux has a default of pass-through.

Decomposition:
- Shared package:
  - DATA_WIDTH and SHAMT_WIDTH defaults.
  - State encodings: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Stage-counter width (3 bits, terminal value 4).
- Sub-module my_rightshift_stage (combinational):
  - Inputs: data_in[31:0], stage_sel[2:0], enable, fill_bit.
  - Output: data_out[31:0], equal to data_in shifted right by 2^stage_sel with fill_bit in the vacated MSBs when enable=1, else data_in.
  - Built as generate loops, one per shift distance, plus a 5:1 select.
- Top level holds the FSM, the counter and the capture registers; it instantiates one stage.

Test Plan:
- Logical shift: A=0x80000000, shamt=4, arith=0, start at E0 -> busy high from E0 to E5; RDY high one cycle after E5; result=0x08000000.
- Arithmetic shift, max amount: A=0x80000000, shamt=31, arith=1 -> result=0xFFFFFFFF. Repeat with A=0x7FFFFFFF -> result=0x00000000.
- Zero shift: A=0xDEADBEEF, shamt=0, arith=1 -> result=0xDEADBEEF, RDY still after exactly 5 shift edges.
- Start while busy: A=0x0000F000, shamt=8, logical; second start at E2 with A=0xFFFFFFFF, shamt=1 -> single RDY pulse, result=0x000000F0, no second operation launched.
- Reset mid-operation: start at E0, reset_n low between E2 and E3 -> outputs immediately 0, no RDY. After release, A=0x00000100, shamt=8 -> result=0x00000001.
- Back-to-back: assert a new start (A=0xF0000000, shamt=28, arith=1) in the RDY cycle of the previous operation -> accepted at E6; RDY one cycle after E11 with result=0xFFFFFFFF; RDY is never high on two consecutive cycles.
